// File: rtl/led_adc_sequencer_pkg.sv
// Shared types and constants for the LED/ADC sequencer: the FSM state encoding,
// the analog front-end field widths and the ADC saturation codes.
package led_adc_sequencer_pkg;

  localparam int unsigned ADC_W = 8;
  localparam int unsigned DC_W  = 7;
  localparam int unsigned PGA_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [ADC_W-1:0] ADC_SAT_LO = 8'd0;
  localparam logic [ADC_W-1:0] ADC_SAT_HI = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RED_SETTLE = 3'd1,
    ST_RED_ACQ    = 3'd2,
    ST_IR_SETTLE  = 3'd3,
    ST_IR_ACQ     = 3'd4
  } state_e;

  // A raw sample at either rail means the front end was clipping.
  function automatic logic is_sat(input logic [ADC_W-1:0] i_s);
    return (i_s == ADC_SAT_LO) || (i_s == ADC_SAT_HI);
  endfunction

endpackage

// File: rtl/led_adc_sequencer_chan_accum.sv
// Burst accumulator shared by both channels.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_clear         zero the running sum and saturation flag
//   i_en            add i_sample into the running sum this cycle
//   i_sample        raw ADC sample
//   o_mean_c        (sum + i_sample) >> AVG_LOG2, i.e. the mean including the current sample
//   o_sat_c         saturation seen so far, including the current sample
module led_adc_sequencer_chan_accum
  import led_adc_sequencer_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [ADC_W-1:0] i_sample,
  output logic [ADC_W-1:0] o_mean_c,
  output logic             o_sat_c
);

  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;

  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [ACC_W-1:0] w_sum;

  // Results include the sample arriving this cycle so the last burst cycle can commit directly.
  assign w_sum    = r_acc + ACC_W'(i_sample);
  assign o_mean_c = ADC_W'(w_sum >> AVG_LOG2);
  assign o_sat_c  = r_sat | is_sat(i_sample);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_sum;
      r_sat <= o_sat_c;
    end
  end

endmodule

// File: rtl/led_adc_sequencer.sv
// Runtime RED/IR LED scheduler: applies per-channel DC compensation and PGA gain,
// waits a settling window, averages an ADC burst per channel and hands one
// RED/IR pair per frame downstream over valid/ready.
// Ports:
//   CLK, rst                  clock, synchronous active-high reset
//   en                        run enable; low aborts to IDLE
//   cfg_valid, red_*/ir_*     shadow configuration write strobe and values
//   ADC                       raw conversion result
//   LED_RED, LED_IR           LED enables (mutually exclusive)
//   DC_Comp, PGA_Gain         analog front-end settings for the lit channel
//   RED/IR_ADC_Value, *_sat   averaged pair and per-channel clip flags
//   out_valid, out_ready      output handshake
//   overrun                   sticky: a completed pair was dropped
module led_adc_sequencer
  import led_adc_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DC_W-1:0]  red_dc,
  input  logic [DC_W-1:0]  ir_dc,
  input  logic [PGA_W-1:0] red_pga,
  input  logic [PGA_W-1:0] ir_pga,
  input  logic [ADC_W-1:0] ADC,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic             red_sat,
  output logic             ir_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACQ_LAST    = CNT_W'((1 << AVG_LOG2) - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_led_red, w_led_red_nxt;
  logic             r_led_ir, w_led_ir_nxt;
  logic [DC_W-1:0]  r_dc, w_dc_nxt;
  logic [PGA_W-1:0] r_pga, w_pga_nxt;

  logic             w_acc_clear, w_acc_en, w_load_act, w_red_done, w_frame_done;
  logic [ADC_W-1:0] w_mean;
  logic             w_sat;

  logic [DC_W-1:0]  r_sh_red_dc, r_sh_ir_dc, r_act_ir_dc;
  logic [PGA_W-1:0] r_sh_red_pga, r_sh_ir_pga, r_act_ir_pga;
  logic [ADC_W-1:0] r_red_val, r_red_out, r_ir_out;
  logic             r_red_sat, r_red_sat_out, r_ir_sat_out;
  logic             r_out_valid, r_overrun;

  led_adc_sequencer_chan_accum #(.AVG_LOG2(AVG_LOG2)) u_chan_accum (
    .i_clk    (CLK),
    .i_rst    (rst),
    .i_clear  (w_acc_clear),
    .i_en     (w_acc_en),
    .i_sample (ADC),
    .o_mean_c (w_mean),
    .o_sat_c  (w_sat)
  );

  // State, phase counter and analog outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_led_red <= 1'b0;
      r_led_ir  <= 1'b0;
      r_dc      <= '0;
      r_pga     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_led_red <= w_led_red_nxt;
      r_led_ir  <= w_led_ir_nxt;
      r_dc      <= w_dc_nxt;
      r_pga     <= w_pga_nxt;
    end
  end

  // Next state; LED/setting changes are computed together so they switch on the same edge
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_led_red_nxt = 1'b0;
    w_led_ir_nxt  = 1'b0;
    w_dc_nxt      = r_dc;
    w_pga_nxt     = r_pga;
    w_acc_clear   = 1'b0;
    w_acc_en      = 1'b0;
    w_load_act    = 1'b0;
    w_red_done    = 1'b0;
    w_frame_done  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt   = ST_RED_SETTLE;
          w_cnt_nxt     = '0;
          w_led_red_nxt = 1'b1;
          w_dc_nxt      = r_sh_red_dc;
          w_pga_nxt     = r_sh_red_pga;
          w_load_act    = 1'b1;
        end
      end
      ST_RED_SETTLE: begin
        w_led_red_nxt = 1'b1;
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_RED_ACQ;
          w_cnt_nxt   = '0;
          w_acc_clear = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RED_ACQ: begin
        w_led_red_nxt = 1'b1;
        w_acc_en      = 1'b1;
        if (r_cnt == ACQ_LAST) begin
          w_state_nxt   = ST_IR_SETTLE;
          w_cnt_nxt     = '0;
          w_red_done    = 1'b1;
          w_led_red_nxt = 1'b0;
          w_led_ir_nxt  = 1'b1;
          w_dc_nxt      = r_act_ir_dc;
          w_pga_nxt     = r_act_ir_pga;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_IR_SETTLE: begin
        w_led_ir_nxt = 1'b1;
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_IR_ACQ;
          w_cnt_nxt   = '0;
          w_acc_clear = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_IR_ACQ: begin
        w_led_ir_nxt = 1'b1;
        w_acc_en     = 1'b1;
        if (r_cnt == ACQ_LAST) begin
          w_state_nxt   = ST_RED_SETTLE;
          w_cnt_nxt     = '0;
          w_frame_done  = 1'b1;
          w_led_ir_nxt  = 1'b0;
          w_led_red_nxt = 1'b1;
          w_dc_nxt      = r_sh_red_dc;
          w_pga_nxt     = r_sh_red_pga;
          w_load_act    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Abort wins over everything: no commit, no partial result, settings held.
    if (!en && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_cnt_nxt     = '0;
      w_led_red_nxt = 1'b0;
      w_led_ir_nxt  = 1'b0;
      w_dc_nxt      = r_dc;
      w_pga_nxt     = r_pga;
      w_acc_en      = 1'b0;
      w_load_act    = 1'b0;
      w_red_done    = 1'b0;
      w_frame_done  = 1'b0;
    end
  end

  // Shadow/active configuration, staged RED result and output handshake
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_sh_red_dc   <= '0;
      r_sh_ir_dc    <= '0;
      r_sh_red_pga  <= '0;
      r_sh_ir_pga   <= '0;
      r_act_ir_dc   <= '0;
      r_act_ir_pga  <= '0;
      r_red_val     <= '0;
      r_red_sat     <= 1'b0;
      r_red_out     <= '0;
      r_ir_out      <= '0;
      r_red_sat_out <= 1'b0;
      r_ir_sat_out  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (cfg_valid) begin
        r_sh_red_dc  <= red_dc;
        r_sh_ir_dc   <= ir_dc;
        r_sh_red_pga <= red_pga;
        r_sh_ir_pga  <= ir_pga;
      end
      // IR settings are frozen with the RED entry so a frame always uses one config.
      if (w_load_act) begin
        r_act_ir_dc  <= r_sh_ir_dc;
        r_act_ir_pga <= r_sh_ir_pga;
      end
      if (w_red_done) begin
        r_red_val <= w_mean;
        r_red_sat <= w_sat;
      end
      // A commit may reuse the slot being accepted in the same cycle.
      if (w_frame_done && (!r_out_valid || out_ready)) begin
        r_red_out     <= r_red_val;
        r_ir_out      <= w_mean;
        r_red_sat_out <= r_red_sat;
        r_ir_sat_out  <= w_sat;
        r_out_valid   <= 1'b1;
      end else begin
        if (w_frame_done) r_overrun <= 1'b1;
        if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      end
    end
  end

  assign LED_RED       = r_led_red;
  assign LED_IR        = r_led_ir;
  assign DC_Comp       = r_dc;
  assign PGA_Gain      = r_pga;
  assign RED_ADC_Value = r_red_out;
  assign IR_ADC_Value  = r_ir_out;
  assign red_sat       = r_red_sat_out;
  assign ir_sat        = r_ir_sat_out;
  assign out_valid     = r_out_valid;
  assign overrun       = r_overrun;

endmodule

// File: doc/led_adc_sequencer.md
# led_adc_sequencer

Runtime scheduler for the optical front end once calibration has produced per-channel settings. It time-multiplexes the RED and IR LEDs. It applies each channel's stored DC compensation and PGA gain to the analog path, waits a settling window, and averages a burst of ADC samples per channel. It hands one RED/IR sample pair per frame to the downstream SpO2 datapath over a valid/ready handshake.

## Interface
- SETTLE_CYCLES, 4: cycles after an LED/setting switch before ADC samples are taken (1..255)
- AVG_LOG2, 2: log2 of samples averaged per channel per frame (0..4)
- CLK  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; low aborts to IDLE
- cfg_valid  in  1  one-cycle strobe, latches the four cfg inputs into shadow registers
- red_dc, ir_dc  in  7  DC compensation codes per channel
- red_pga, ir_pga  in  4  PGA gain codes per channel
- ADC  in  8  ADC conversion result, sampled on CLK
- LED_RED, LED_IR  out  1  LED enables, never both high
- DC_Comp  out  7  DC compensation code to analog front end
- PGA_Gain  out  4  PGA gain code to analog front end
- RED_ADC_Value, IR_ADC_Value  out  8  averaged sample pair
- red_sat, ir_sat  out  1  any raw sample of that channel's burst was 0 or 255
- out_valid  out  1  pair available
- out_ready  in  1  consumer accepts pair
- overrun  out  1  sticky: a completed pair was dropped

## Operation
- Reset: state IDLE; all outputs 0; shadow cfg 0; accumulators 0.
- Shadow cfg: cfg_valid writes shadow regs in any state. The active copy is taken from shadow only on entry to RED_SETTLE, so a mid-frame update takes effect next frame.
- States: IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ.
- IDLE: LEDs off. DC_Comp/PGA_Gain hold their last values. If en=1, go to RED_SETTLE.
- RED_SETTLE: LED_RED=1, DC_Comp=red_dc, PGA_Gain=red_pga. Count SETTLE_CYCLES cycles, then go to RED_ACQ.
- RED_ACQ: accumulate ADC for N=2^AVG_LOG2 cycles. OR (ADC==0 || ADC==255) into red_sat_acc. Go to IR_SETTLE.
- IR_SETTLE/IR_ACQ: as for RED, using IR settings, LED_IR=1, LED_RED=0.
- After the last IR_ACQ cycle, go to RED_SETTLE if en=1, else IDLE.
- Arithmetic: accumulator width 8+AVG_LOG2, unsigned, no overflow possible. Result = acc >> AVG_LOG2, truncating. Accumulators clear on entry to each ACQ state.
- Output commit, on the last IR_ACQ cycle:
  - If out_valid=0, or out_valid=1 with out_ready=1 in that same cycle: load both values and both sat flags; out_valid=1 next cycle.
  - Otherwise: drop the new pair, keep the old pair and out_valid, set overrun.
- Handshake: out_valid falls the cycle after out_valid && out_ready, unless a commit occurs in the same cycle. Output data is stable while out_valid=1 and out_ready=0.
- en low in any non-IDLE state: IDLE next cycle, LEDs off, partial accumulation discarded. out_valid and the pending pair are unaffected and remain deliverable.
- overrun clears only on rst.
- rst mid-frame: everything returns to reset values next cycle, including a pending pair.

## Timing
- LED switch, DC_Comp and PGA_Gain change on the same edge (state entry); no cycle with both LEDs on.
- en sampled high at edge k gives LED_RED=1 from k+1.
- First RED sample at edge k+1+SETTLE_CYCLES.
- Frame length F = 2*(SETTLE_CYCLES+2^AVG_LOG2); default 16 cycles.
- out_valid rises F cycles after the first RED_SETTLE cycle, i.e. one cycle after the last IR sample edge.
- Throughput: one pair per F cycles while en=1. Zero-wait consumer never sees overrun.

## Structure
- Shared package: state encoding enum, ADC width (8), DC width (7), PGA width (4), saturation codes 8'd0/8'd255.
- One natural sub-module: chan_accum (clear, enable, 8-bit in, saturation detect, shifted mean out), instantiated once and reused for both channels, with separate result and sat registers per channel in the top.

## Test plan
- Reset with defaults, cfg red 7'd40/4'd3, ir 7'd90/4'd5, en=1, ADC = RED 100, IR 200 -> first out_valid 16 cycles after LED_RED rise. Values 100/200, sats 0. DC_Comp/PGA follow 40/3 then 90/5 with LED switches.
- RED burst 10,20,30,41 (AVG_LOG2=2) -> RED_ADC_Value=25 (101>>2). One IR sample 255 -> ir_sat=1.
- out_ready held 0 for two frames -> first pair retained, overrun=1 at second commit. out_ready=1 -> out_valid falls next cycle, overrun stays 1.
- cfg_valid with red_dc=7'd70 during IR_ACQ -> current frame unchanged. DC_Comp=70 at next RED_SETTLE entry.
- en dropped during RED_ACQ with a pending pair -> LEDs off next cycle. No new commit. Pending pair still accepted on out_ready. Re-enable restarts at RED_SETTLE with fresh accumulation.
- rst asserted during IR_SETTLE with out_valid=1 -> all outputs 0 next cycle, out_valid=0, overrun=0.
